ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and initializer for the 32-word × 3-bit single-port synchronous RAM (registered q, write-through on write). After reset it zero-fills every RAM word, then shares the single port between requester 0 (switch/user port) and requester 1 (autonomous scanner or display refresh). It drives the RAM's address, data, write enable and clock, and routes read data back to the requester that issued the read.

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/ram_arbiter_if.sv | 46 ++++
 rtl/rr_arbiter2.sv | 59 +++++
 rtl/ram_arbiter.sv | 109 ++++++++++
 tb/tb_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and default sizes for the RAM arbiter/initializer.
// Contents : DEF_ADDR_W / DEF_DATA_W defaults, arbiter state enum and the
//            requester-index type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Identifies one of the two requesters (0 = user port, 1 = scanner).
  typedef logic [0:0] req_idx_t;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module   : ram_arbiter_if
// Purpose  : Bundles the two requester command ports, the shared read-back
//            path and the single-port RAM connection of ram_arbiter.
// Modports : slave  - the arbiter (consumes requests and ram_q, drives
//                     grants, rvalids, rdata, busy and the RAM port)
//            master - the environment (requesters plus the RAM itself)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0,   req1;
  logic              we0,    we1;
  logic [ADDR_W-1:0] addr0,  addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0,   gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           ram_addr, ram_data, ram_wren
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           ram_addr, ram_data, ram_wren
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin pick. The grant is combinational from the
//            request vector and a priority pointer; the pointer moves to the
//            losing/idle requester on every grant.
// Ports    : clk, reset (async, active-high)
//            run  - grants are only issued while high
//            req  - request vector, bit N = requester N
//            gnt  - one-hot grant (or zero)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_idx_t ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (run) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_q == req_idx_t'(0)) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer names the requester that was NOT served, so a lone requester
  // still wins back-to-back while two contenders alternate.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = req_idx_t'(1);
    end else if (gnt[1]) begin
      ptr_d = req_idx_t'(0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= req_idx_t'(0);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Zero-fills a single-port synchronous RAM after reset, then
//            shares its port between two requesters with round-robin
//            arbitration and routes read data back with per-requester rvalid.
// Ports    : clk   - arbiter and RAM clock
//            reset - asynchronous, active-high
//            bus   - ram_arbiter_if.slave (requests, grants, read-back,
//                    busy, RAM address/data/wren/q)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  // Must match the widths of the connected ram_arbiter_if instance.
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)(
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              run;
  logic [1:0]        gnt;

  assign run = (state_q == ST_RUN);

  rr_arbiter2 u_rr_arbiter2 (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .req   ({bus.req1, bus.req0}),
    .gnt   (gnt)
  );

  // Fill sequencing: leave INIT once the write to the last word is issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end
  end

  // A read grant now means ram_q holds that requester's data next cycle.
  always_comb begin
    rvalid0_d = gnt[0] & ~bus.we0;
    rvalid1_d = gnt[1] & ~bus.we1;
  end

  // RAM port mux. Idle RUN cycles park on addr0 with the write disabled.
  always_comb begin
    bus.ram_wren = 1'b0;
    bus.ram_addr = bus.addr0;
    bus.ram_data = {DATA_W{1'b0}};
    if (!run) begin
      bus.ram_wren = 1'b1;
      bus.ram_addr = cnt_q;
    end else if (gnt[0]) begin
      bus.ram_wren = bus.we0;
      bus.ram_addr = bus.addr0;
      if (bus.we0) begin
        bus.ram_data = bus.wdata0;
      end
    end else if (gnt[1]) begin
      bus.ram_wren = bus.we1;
      bus.ram_addr = bus.addr1;
      if (bus.we1) begin
        bus.ram_data = bus.wdata1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= {ADDR_W{1'b0}};
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = bus.ram_q;
  assign bus.busy    = ~run;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a behavioural RAM, a
//            transaction-level reference model compared every cycle, and
//            directed scenarios with literal expected values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;

  int errors;
  int checks;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered q, write-through on write.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wren) begin
      ram_mem[bus.ram_addr] <= bus.ram_data;
      bus.ram_q             <= bus.ram_data;
    end else begin
      bus.ram_q <= ram_mem[bus.ram_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: tracks elapsed fill cycles, the contents of memory, who
  // was served most recently and the read whose data is due next cycle.
  // --------------------------------------------------------------------------
  initial begin
    int            since_rst;
    int            last_win;
    logic [DW-1:0] mem [DEPTH];
    bit            pend_v;
    int            pend_who;
    int            pend_data;
    int            n_since;
    int            n_last;
    bit            n_pend_v;
    int            n_pend_who;
    int            n_pend_data;
    int            wr_addr;
    int            wr_data;
    bit            wr_en;
    int            w;
    bit            r0, r1;

    since_rst = 0;
    last_win  = 1;
    pend_v    = 1'b0;
    pend_who  = 0;
    pend_data = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    forever begin
      @(negedge clk);
      wr_en = 1'b0; wr_addr = 0; wr_data = 0;
      n_pend_v = 1'b0; n_pend_who = 0; n_pend_data = 0;
      n_since = since_rst; n_last = last_win;
      if (rst) begin
        chk("rst_busy",   int'(bus.busy),     1);
        chk("rst_gnt0",   int'(bus.gnt0),     0);
        chk("rst_gnt1",   int'(bus.gnt1),     0);
        chk("rst_rvalid0", int'(bus.rvalid0), 0);
        chk("rst_rvalid1", int'(bus.rvalid1), 0);
        chk("rst_wren",   int'(bus.ram_wren), 1);
        chk("rst_addr",   int'(bus.ram_addr), 0);
        chk("rst_data",   int'(bus.ram_data), 0);
      end else begin
        chk("mdl_rvalid0", int'(bus.rvalid0), (pend_v && pend_who == 0) ? 1 : 0);
        chk("mdl_rvalid1", int'(bus.rvalid1), (pend_v && pend_who == 1) ? 1 : 0);
        if (pend_v) chk("mdl_rdata", int'(bus.rdata), pend_data);
        if (since_rst < DEPTH) begin
          chk("mdl_busy", int'(bus.busy),     1);
          chk("mdl_gnt0", int'(bus.gnt0),     0);
          chk("mdl_gnt1", int'(bus.gnt1),     0);
          chk("mdl_wren", int'(bus.ram_wren), 1);
          chk("mdl_addr", int'(bus.ram_addr), since_rst);
          chk("mdl_data", int'(bus.ram_data), 0);
          wr_en = 1'b1; wr_addr = since_rst; wr_data = 0;
          n_since = since_rst + 1;
        end else begin
          r0 = bus.req0; r1 = bus.req1;
          if (r0 && r1)  w = (last_win == 0) ? 1 : 0;
          else if (r0)   w = 0;
          else if (r1)   w = 1;
          else           w = -1;
          chk("mdl_busy", int'(bus.busy), 0);
          chk("mdl_gnt0", int'(bus.gnt0), (w == 0) ? 1 : 0);
          chk("mdl_gnt1", int'(bus.gnt1), (w == 1) ? 1 : 0);
          if (w < 0) begin
            chk("mdl_wren", int'(bus.ram_wren), 0);
            chk("mdl_addr", int'(bus.ram_addr), int'(bus.addr0));
            chk("mdl_data", int'(bus.ram_data), 0);
          end else begin
            bit we;
            int a;
            int d;
            we = (w == 0) ? bus.we0 : bus.we1;
            a  = (w == 0) ? int'(bus.addr0) : int'(bus.addr1);
            d  = (w == 0) ? int'(bus.wdata0) : int'(bus.wdata1);
            chk("mdl_wren", int'(bus.ram_wren), we ? 1 : 0);
            chk("mdl_addr", int'(bus.ram_addr), a);
            chk("mdl_data", int'(bus.ram_data), we ? d : 0);
            n_last = w;
            if (we) begin
              wr_en = 1'b1; wr_addr = a; wr_data = d;
            end else begin
              n_pend_v = 1'b1; n_pend_who = w; n_pend_data = int'(mem[a]);
            end
          end
        end
      end
      @(posedge clk);
      if (rst) begin
        since_rst = 0;
        last_win  = 1;
        pend_v    = 1'b0;
        mem[0]    = '0;
      end else begin
        if (wr_en) mem[wr_addr] = DW'(wr_data);
        since_rst = n_since;
        last_win  = n_last;
        pend_v    = n_pend_v;
        pend_who  = n_pend_who;
        pend_data = n_pend_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r0, input bit w0, input int a0, input int d0,
                       input bit r1, input bit w1, input int a1, input int d1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = AW'(a0); bus.wdata0 = DW'(d0);
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = AW'(a1); bus.wdata1 = DW'(d1);
  endtask

  task automatic step(input bit r0, input bit w0, input int a0, input int d0,
                      input bit r1, input bit w1, input int a1, input int d1);
    cyc();
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Positioned at posedge+1 of the release cycle; walks the whole fill.
  task automatic fill_check();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("fill_busy", int'(bus.busy),     1);
      chk("fill_addr", int'(bus.ram_addr), i);
      chk("fill_wren", int'(bus.ram_wren), 1);
    end
    @(negedge clk);
    chk("fill_done_busy", int'(bus.busy), 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.ram_q = '0;

    // Reset and initial zero-fill
    cyc(); cyc(); cyc();
    rst = 1'b0;
    fill_check();

    // Read of address 17 after the fill returns zero
    step(1, 0, 17, 0, 0, 0, 0, 0);
    chk("rd17_gnt0", int'(bus.gnt0), 1);
    idle_step();
    chk("rd17_rvalid0", int'(bus.rvalid0), 1);
    chk("rd17_rdata",   int'(bus.rdata),   0);

    // Write then read back on requester 0
    step(1, 1, 5, 6, 0, 0, 0, 0);
    chk("wr5_gnt0", int'(bus.gnt0), 1);
    step(1, 0, 5, 0, 0, 0, 0, 0);
    chk("rd5_gnt0", int'(bus.gnt0), 1);
    chk("wr5_rvalid0", int'(bus.rvalid0), 0);
    idle_step();
    chk("rd5_rvalid0", int'(bus.rvalid0), 1);
    chk("rd5_rdata",   int'(bus.rdata),   6);
    chk("rd5_rvalid1", int'(bus.rvalid1), 0);

    // Preload addr2=1 (req0), addr3=4 (req1); req1 last so req0 wins next
    step(1, 1, 2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 3, 4);
    chk("pre3_gnt1", int'(bus.gnt1), 1);

    // Both reading continuously: grants alternate starting with 0
    step(1, 0, 2, 0, 1, 0, 3, 0);
    chk("alt_a_gnt0", int'(bus.gnt0), 1);
    chk("alt_a_gnt1", int'(bus.gnt1), 0);
    step(1, 0, 2, 0, 1, 0, 3, 0);
    chk("alt_b_gnt1", int'(bus.gnt1), 1);
    chk("alt_b_rvalid0", int'(bus.rvalid0), 1);
    chk("alt_b_rdata", int'(bus.rdata), 1);
    step(1, 0, 2, 0, 1, 0, 3, 0);
    chk("alt_c_gnt0", int'(bus.gnt0), 1);
    chk("alt_c_rvalid1", int'(bus.rvalid1), 1);
    chk("alt_c_rdata", int'(bus.rdata), 4);
    step(1, 0, 2, 0, 1, 0, 3, 0);
    chk("alt_d_gnt1", int'(bus.gnt1), 1);
    chk("alt_d_rdata", int'(bus.rdata), 1);
    idle_step();
    chk("alt_e_rvalid1", int'(bus.rvalid1), 1);
    chk("alt_e_rdata", int'(bus.rdata), 4);

    // Requester 1 alone: back-to-back writes then readback
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1, i, 7 - i);
      chk("solo_wr_gnt1", int'(bus.gnt1), 1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(0, 0, 0, 0, 1, 0, i, 0);
      else       idle_step();
      if (i < 4) chk("solo_rd_gnt1", int'(bus.gnt1), 1);
      if (i > 0) begin
        chk("solo_rd_rvalid1", int'(bus.rvalid1), 1);
        chk("solo_rd_rdata",   int'(bus.rdata),   8 - i);
      end
    end

    // Move pointer to 1 with a req0 read of addr 9 (zero from the fill)
    step(1, 0, 9, 0, 0, 0, 0, 0);
    idle_step();
    chk("rd9_pre_rdata", int'(bus.rdata), 0);
    // Contention on addr 9: req1 read wins first and sees the old value
    step(1, 1, 9, 3, 1, 0, 9, 0);
    chk("rw9_gnt1", int'(bus.gnt1), 1);
    chk("rw9_gnt0", int'(bus.gnt0), 0);
    step(1, 1, 9, 3, 0, 0, 0, 0);
    chk("rw9_gnt0_next", int'(bus.gnt0), 1);
    chk("rw9_rvalid1", int'(bus.rvalid1), 1);
    chk("rw9_rdata_old", int'(bus.rdata), 0);
    step(1, 0, 9, 0, 0, 0, 0, 0);
    idle_step();
    chk("rd9_rvalid0", int'(bus.rvalid0), 1);
    chk("rd9_rdata_new", int'(bus.rdata), 3);

    // Reset lands while a read is in flight
    step(1, 0, 5, 0, 0, 0, 0, 0);
    chk("rr_gnt0", int'(bus.gnt0), 1);
    #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rr_rvalid0", int'(bus.rvalid0), 0);
    chk("rr_busy", int'(bus.busy), 1);
    chk("rr_addr", int'(bus.ram_addr), 0);
    cyc(); cyc();
    rst = 1'b0;
    fill_check();

    // The refill cleared the earlier write to addr 5
    step(1, 0, 5, 0, 0, 0, 0, 0);
    idle_step();
    chk("post_rr_rvalid0", int'(bus.rvalid0), 1);
    chk("post_rr_rdata", int'(bus.rdata), 0);

    idle_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
